pipe_em_skidreg: RTL and testbench
==================================

# pipe_em_skidreg

Parametrised EX/MEM pipeline register with valid/ready flow control and a two-entry skid buffer. It sits between the execute and memory stages of the pipelined CPU. It carries the ALU result, store data, destination register number and the three write/memory control bits. It adds stall back-pressure, flush and bubble handling, and full-throughput elastic buffering, none of which the plain EX/MEM register has.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store-data payloads
- RN_W, 5, width of destination register number
- ZERO_IDLE, 0, 1 = payload outputs read 0 whenever m_valid=0; 0 = payload outputs hold the last head-entry value

Ports:
- clk  in  1  clock; all state updates on posedge
- clrn  in  1  reset, asynchronous, active-high (clrn=1 resets)
- flush  in  1  synchronous flush; empties the buffer
- e_valid  in  1  execute stage presents a valid instruction
- e_ready  out  1  block can accept this cycle
- ewreg, em2reg, ewmem  in  1 each  control bits from EX
- ealu, eb  in  DATA_W each  ALU result, store data
- ern  in  RN_W  destination register
- m_valid  out  1  head entry valid
- m_ready  in  1  memory stage consumes head this cycle
- mwreg, mm2reg, mwmem  out  1 each  head control bits, forced 0 when m_valid=0
- malu, mb  out  DATA_W each  head payload
- mrn  out  RN_W  head destination register
- occ  out  2  entries held (0..2)

## Operation
- Storage: head entry H drives the outputs; skid entry S holds overflow. Each entry stores the 3 control bits and the payload.
- State: EMPTY (occ=0), ONE (H valid), TWO (H and S valid). e_ready = (state != TWO), decoded directly from state. m_valid = (state != EMPTY).
- push = e_valid & e_ready; pop = m_valid & m_ready.
- Transitions (flush=0):
  - EMPTY: push -> ONE, H<=in.
  - ONE: push&pop -> ONE, H<=in. Push only -> TWO, S<=in. Pop only -> EMPTY.
  - TWO: pop -> ONE, H<=S. No pop -> TWO, hold. A push cannot occur in TWO because e_ready=0.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- flush=1 overrides everything:
  - Next state is EMPTY and both entries are invalidated.
  - A push and a pop in the same cycle are both discarded.
  - e_ready is still driven from the current state during the flush cycle.
  - When ZERO_IDLE=1, stored payloads are cleared to 0.
- Control gating: mwreg/mm2reg/mwmem = stored bits & m_valid. A bubble therefore never writes the register file or memory.
- Payload outputs when m_valid=0: 0 if ZERO_IDLE=1, otherwise the last H contents.
- Reset (clrn=1, asynchronous, takes effect immediately, including mid-transfer):
  - state=EMPTY, all entry fields 0.
  - Resulting outputs: m_valid=0, mwreg=mm2reg=mwmem=0, malu=mb=0, mrn=0, occ=0, e_ready=1.
- Widths: payloads pass through unmodified. No arithmetic except occ.

## Timing
- Latency: an input accepted at edge N is visible on outputs (m_valid=1) after edge N, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained while m_ready=1.
- Back-pressure:
  - m_ready falling while in ONE with a push still lands that push in S. e_ready drops after that edge.
  - e_ready returns to 1 the cycle after the first pop from TWO.
- e_ready has no combinational path from m_ready or e_valid. It is a function of registered state only.
- m_valid and all outputs are registered or gated by registered state. There is no combinational path from e_* inputs to m_* outputs.
- Flush asserted at edge N: m_valid=0 and e_ready=1 after edge N. A push at edge N+1 is accepted normally.
- clrn deassertion: the first edge with clrn=0 may accept a push.

## Test plan
- Reset: assert clrn mid-stream with occ=2 -> immediately m_valid=0, mwreg=mm2reg=mwmem=0, malu=mb=0, mrn=0, occ=0, e_ready=1.
- Streaming: m_ready=1, push ealu=1..8, ern=1..8 on consecutive cycles -> malu=1..8 out one cycle later, each exactly once, occ stays 1.
- Stall/skid: push A(ealu=0xA), then m_ready=0 and push B(0xB) -> occ=2, e_ready=0, malu=0xA held. Raise m_ready -> 0xA then 0xB out on consecutive cycles, e_ready=1 one cycle after first pop.
- Flush: occ=2, flush=1 with e_valid=1, m_ready=1 -> next cycle m_valid=0, occ=0, neither entry nor the new input is ever output.
- Bubble gating: push ewreg=em2reg=ewmem=1, pop it, then idle -> control outputs 0 while m_valid=0. With ZERO_IDLE=1, malu=mb=mrn=0. With ZERO_IDLE=0, payloads hold the last value.
- Parameters: DATA_W=64, RN_W=6, push ealu=0xFFFF_0000_1234_5678, ern=63 -> identical values on malu/mrn.

Source files
------------

// File: rtl/pipe_em_skidreg.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Head entry drives the memory stage; skid entry absorbs the cycle after back-pressure.
module pipe_em_skidreg #(
  parameter int DATA_W    = 32,
  parameter int RN_W      = 5,
  parameter bit ZERO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [DATA_W-1:0] ealu,
  input  logic [DATA_W-1:0] eb,
  input  logic [RN_W-1:0]   ern,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [DATA_W-1:0] malu,
  output logic [DATA_W-1:0] mb,
  output logic [RN_W-1:0]   mrn,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] b;
    logic [RN_W-1:0]   rn;
  } ent_t;

  state_t r_state;
  state_t w_state_n;
  ent_t   r_h;
  ent_t   r_s;
  ent_t   w_in;
  logic   w_push;
  logic   w_pop;
  logic   w_ld_h_in;
  logic   w_ld_s_in;
  logic   w_ld_h_s;
  logic   w_zero;

  assign w_in = {ewreg, em2reg, ewmem, ealu, eb, ern};

  assign e_ready = (r_state != TWO);
  assign m_valid = (r_state != EMPTY);
  assign occ     = r_state;

  assign w_push = e_valid & e_ready;
  assign w_pop  = m_valid & m_ready;

  always_comb begin
    w_state_n = r_state;
    w_ld_h_in = 1'b0;
    w_ld_s_in = 1'b0;
    w_ld_h_s  = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_n = ONE;
          w_ld_h_in = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_ld_h_in = 1'b1;
        end else if (w_push) begin
          w_state_n = TWO;
          w_ld_s_in = 1'b1;
        end else if (w_pop) begin
          w_state_n = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_state_n = ONE;
          w_ld_h_s  = 1'b1;
        end
      end
      default: w_state_n = EMPTY;
    endcase
    // flush wins over any same-cycle push or pop
    if (flush) begin
      w_state_n = EMPTY;
      w_ld_h_in = 1'b0;
      w_ld_s_in = 1'b0;
      w_ld_h_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state <= EMPTY;
      r_h     <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_state_n;
      if (flush && ZERO_IDLE) begin
        r_h <= '0;
        r_s <= '0;
      end else begin
        if (w_ld_h_in) begin
          r_h <= w_in;
        end else if (w_ld_h_s) begin
          r_h <= r_s;
        end
        if (w_ld_s_in) begin
          r_s <= w_in;
        end
      end
    end
  end

  assign w_zero = ZERO_IDLE && !m_valid;

  assign mwreg  = r_h.wreg  & m_valid;
  assign mm2reg = r_h.m2reg & m_valid;
  assign mwmem  = r_h.wmem  & m_valid;
  assign malu   = w_zero ? '0 : r_h.alu;
  assign mb     = w_zero ? '0 : r_h.b;
  assign mrn    = w_zero ? '0 : r_h.rn;

endmodule

// File: tb/tb_pipe_em_skidreg.sv
// Scoreboard bench for pipe_em_skidreg: a wide ZERO_IDLE=1 instance and a
// default-width ZERO_IDLE=0 instance share one stimulus stream.
module tb_pipe_em_skidreg;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [63:0] alu;
    logic [63:0] b;
    logic [5:0]  rn;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        flush = 1'b0;
  logic        e_valid = 1'b0;
  logic        ewreg = 1'b0;
  logic        em2reg = 1'b0;
  logic        ewmem = 1'b0;
  logic [63:0] ealu = '0;
  logic [63:0] eb = '0;
  logic [5:0]  ern = '0;
  logic        m_ready = 1'b0;

  logic        a_e_ready, a_m_valid, a_mwreg, a_mm2reg, a_mwmem;
  logic [63:0] a_malu, a_mb;
  logic [5:0]  a_mrn;
  logic [1:0]  a_occ;

  logic        b_e_ready, b_m_valid, b_mwreg, b_mm2reg, b_mwmem;
  logic [31:0] b_malu, b_mb;
  logic [4:0]  b_mrn;
  logic [1:0]  b_occ;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] l_alu = '0;
  logic [31:0] l_b = '0;
  logic [4:0]  l_rn = '0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pipe_em_skidreg #(.DATA_W(64), .RN_W(6), .ZERO_IDLE(1'b1)) u_a (
    .clk(clk), .clrn(clrn), .flush(flush),
    .e_valid(e_valid), .e_ready(a_e_ready),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .ern(ern),
    .m_valid(a_m_valid), .m_ready(m_ready),
    .mwreg(a_mwreg), .mm2reg(a_mm2reg), .mwmem(a_mwmem),
    .malu(a_malu), .mb(a_mb), .mrn(a_mrn), .occ(a_occ)
  );

  pipe_em_skidreg u_b (
    .clk(clk), .clrn(clrn), .flush(flush),
    .e_valid(e_valid), .e_ready(b_e_ready),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu[31:0]), .eb(eb[31:0]), .ern(ern[4:0]),
    .m_valid(b_m_valid), .m_ready(m_ready),
    .mwreg(b_mwreg), .mm2reg(b_mm2reg), .mwmem(b_mwmem),
    .malu(b_malu), .mb(b_mb), .mrn(b_mrn), .occ(b_occ)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic st(input string tag, input int o);
    chk({tag, "_occ_a"}, 64'(a_occ), 64'(o));
    chk({tag, "_occ_b"}, 64'(b_occ), 64'(o));
    chk({tag, "_erdy_a"}, 64'(a_e_ready), 64'(o != 2));
    chk({tag, "_erdy_b"}, 64'(b_e_ready), 64'(o != 2));
    chk({tag, "_mval_a"}, 64'(a_m_valid), 64'(o != 0));
    chk({tag, "_mval_b"}, 64'(b_m_valid), 64'(o != 0));
  endtask

  task automatic step(input bit v, input logic [2:0] c,
                      input logic [63:0] alu, input logic [63:0] bb,
                      input logic [5:0] rn, input bit rdy,
                      input bit fl, input bit acc);
    exp_t x;
    e_valid = v;
    {ewreg, em2reg, ewmem} = c;
    ealu = alu;
    eb = bb;
    ern = rn;
    m_ready = rdy;
    flush = fl;
    if (acc) begin
      x = '{c, alu, bb, rn};
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (fl) q.delete();
    e_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Monitor: pops on every consumed head, checks gating on every bubble.
  always @(negedge clk) begin
    if (clrn) begin
      l_alu = '0;
      l_b = '0;
      l_rn = '0;
    end else if (a_m_valid) begin
      if (q.size() == 0) begin
        chk("extra_out", 64'(a_m_valid), 64'd0);
      end else begin
        e = q[0];
        l_alu = e.alu[31:0];
        l_b = e.b[31:0];
        l_rn = e.rn[4:0];
        if (m_ready && !flush) begin
          void'(q.pop_front());
          chk("out_ctl_a", 64'({a_mwreg, a_mm2reg, a_mwmem}), 64'(e.ctl));
          chk("out_alu_a", a_malu, e.alu);
          chk("out_b_a", a_mb, e.b);
          chk("out_rn_a", 64'(a_mrn), 64'(e.rn));
          chk("out_ctl_b", 64'({b_mwreg, b_mm2reg, b_mwmem}), 64'(e.ctl));
          chk("out_alu_b", 64'(b_malu), 64'(e.alu[31:0]));
          chk("out_b_b", 64'(b_mb), 64'(e.b[31:0]));
          chk("out_rn_b", 64'(b_mrn), 64'(e.rn[4:0]));
        end
      end
    end else begin
      chk("idle_ctl_a", 64'({a_mwreg, a_mm2reg, a_mwmem}), 64'd0);
      chk("idle_ctl_b", 64'({b_mwreg, b_mm2reg, b_mwmem}), 64'd0);
      chk("idle_pay_a", 64'({a_malu, a_mb, a_mrn} != '0), 64'd0);
      chk("idle_alu_b", 64'(b_malu), 64'(l_alu));
      chk("idle_b_b", 64'(b_mb), 64'(l_b));
      chk("idle_rn_b", 64'(b_mrn), 64'(l_rn));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    st("reset", 0);
    clrn = 1'b0;

    // streaming
    for (int i = 1; i <= 8; i++) begin
      step(1, 3'b101, 64'(i), 64'(i + 100), 6'(i), 1, 0, 1);
      st("stream", 1);
    end
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    st("stream_end", 0);

    // stall and skid
    step(1, 3'b100, 64'hA, 64'hA0, 6'd10, 1, 0, 1);
    st("skid_a", 1);
    step(1, 3'b010, 64'hB, 64'hB0, 6'd11, 0, 0, 1);
    st("skid_b", 2);
    chk("skid_head", a_malu, 64'hA);
    step(1, 3'b001, 64'hC, 64'hC0, 6'd12, 0, 0, 0);
    st("skid_hold", 2);
    chk("skid_hold_head", 64'(b_malu), 64'hA);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    st("skid_pop1", 1);
    chk("skid_next", a_malu, 64'hB);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    st("skid_pop2", 0);

    // flush with both entries full
    step(1, 3'b111, 64'hD, 64'hD0, 6'd13, 0, 0, 1);
    step(1, 3'b111, 64'hE, 64'hE0, 6'd14, 0, 0, 1);
    st("fl_full", 2);
    step(1, 3'b111, 64'hF, 64'hF0, 6'd15, 1, 1, 0);
    st("fl_done", 0);
    chk("fl_hold_b", 64'(b_malu), 64'hD);

    // flush discards a same-cycle push and pop
    step(1, 3'b110, 64'h10, 64'h100, 6'd16, 0, 0, 1);
    step(1, 3'b110, 64'h11, 64'h110, 6'd17, 1, 1, 0);
    st("fl_one", 0);
    step(1, 3'b011, 64'h12, 64'h120, 6'd18, 1, 0, 1);
    st("fl_after", 1);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    st("fl_drain", 0);

    // bubble gating after a full-control push
    step(1, 3'b111, 64'h55, 64'h66, 6'd7, 1, 0, 1);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    chk("bub_ctl_b", 64'({b_mwreg, b_mm2reg, b_mwmem}), 64'd0);
    chk("bub_hold_b", 64'(b_malu), 64'h55);
    chk("bub_zero_a", a_malu, 64'd0);

    // full-width payload
    step(1, 3'b010, 64'hFFFF_0000_1234_5678, 64'h8000_0000_0000_0001,
         6'd63, 1, 0, 1);
    chk("wide_alu", a_malu, 64'hFFFF_0000_1234_5678);
    chk("wide_rn", 64'(a_mrn), 64'd63);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);

    // asynchronous reset with two entries held
    step(1, 3'b111, 64'h21, 64'h210, 6'd21, 0, 0, 1);
    step(1, 3'b111, 64'h22, 64'h220, 6'd22, 0, 0, 1);
    st("rst_pre", 2);
    #2;
    clrn = 1'b1;
    #1;
    q.delete();
    st("rst_mid", 0);
    chk("rst_ctl_a", 64'({a_mwreg, a_mm2reg, a_mwmem}), 64'd0);
    chk("rst_alu_a", a_malu, 64'd0);
    chk("rst_alu_b", 64'(b_malu), 64'd0);
    chk("rst_b_b", 64'(b_mb), 64'd0);
    chk("rst_rn_b", 64'(b_mrn), 64'd0);
    @(posedge clk);
    #1;
    clrn = 1'b0;
    step(1, 3'b100, 64'h33, 64'h330, 6'd3, 1, 0, 1);
    st("rst_first", 1);
    step(0, 3'b000, '0, '0, '0, 1, 0, 0);
    st("rst_drain", 0);

    repeat (2) @(posedge clk);
    #1;
    chk("q_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
